regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU result and requester 1 is the memory load return.
- Drives the register file's write_en/wreg/writedata from a registered output stage.
- Keeps an 8-entry pending-write scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/memory stages and the register file; decode queries it each cycle.

---
 rtl/regfile_wb_arbiter_if.sv | 54 +++++
 rtl/regfile_wb_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback request, scoreboard query and register-file write
// signals shared between the execute/memory stages, decode and the arbiter.
//   req0_*    : ALU writeback request (valid/reg/data in, ready out)
//   req1_*    : load-return writeback request (valid/reg/data in, ready out)
//   sb_*      : decode marks a destination register as pending
//   chk_reg*  : decode source registers; stall reports a pending hazard
//   busy      : pending-write bit per register
//   write_en/wreg/writedata : register file write port
// Modports: slave = arbiter view, master = surrounding pipeline view.
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   localparam int NUM_REGS = 1 << REG_AW;

   logic                req0_valid;
   logic [REG_AW-1:0]   req0_reg;
   logic [DATA_W-1:0]   req0_data;
   logic                req0_ready;
   logic                req1_valid;
   logic [REG_AW-1:0]   req1_reg;
   logic [DATA_W-1:0]   req1_data;
   logic                req1_ready;
   logic                sb_set;
   logic [REG_AW-1:0]   sb_reg;
   logic [REG_AW-1:0]   chk_rega;
   logic [REG_AW-1:0]   chk_regb;
   logic                stall;
   logic [NUM_REGS-1:0] busy;
   logic                write_en;
   logic [REG_AW-1:0]   wreg;
   logic [DATA_W-1:0]   writedata;

   modport slave (
      input  req0_valid, req0_reg, req0_data,
      output req0_ready,
      input  req1_valid, req1_reg, req1_data,
      output req1_ready,
      input  sb_set, sb_reg, chk_rega, chk_regb,
      output stall, busy, write_en, wreg, writedata
   );

   modport master (
      output req0_valid, req0_reg, req0_data,
      input  req0_ready,
      output req1_valid, req1_reg, req1_data,
      input  req1_ready,
      output sb_set, sb_reg, chk_rega, chk_regb,
      input  stall, busy, write_en, wreg, writedata
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU (requester 0)
// and the load return (requester 1) with round-robin arbitration, drives the
// write port from a registered stage, and keeps a per-register pending-write
// scoreboard that decode queries for read-after-write hazards.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : regfile_wb_arbiter_if.slave (requests, scoreboard, write port)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   regfile_wb_arbiter_if.slave     bus
);
   localparam int NUM_REGS = 1 << REG_AW;

   logic                grant0_s;
   logic                grant1_s;

   logic                write_en_q,   write_en_d;
   logic [REG_AW-1:0]   wreg_q,       wreg_d;
   logic [DATA_W-1:0]   writedata_q,  writedata_d;
   logic                last_grant_q, last_grant_d;
   logic [NUM_REGS-1:0] busy_q,       busy_d;

   // Round-robin grant: on contention the requester that did not win last time goes.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (last_grant_q) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (bus.req0_valid) begin
         grant0_s = 1'b1;
      end else if (bus.req1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Next state of the write-port stage: capture the winner, otherwise hold address/data.
   always_comb begin
      write_en_d   = 1'b0;
      wreg_d       = wreg_q;
      writedata_d  = writedata_q;
      last_grant_d = last_grant_q;
      if (grant0_s) begin
         write_en_d   = 1'b1;
         wreg_d       = bus.req0_reg;
         writedata_d  = bus.req0_data;
         last_grant_d = 1'b0;
      end else if (grant1_s) begin
         write_en_d   = 1'b1;
         wreg_d       = bus.req1_reg;
         writedata_d  = bus.req1_data;
         last_grant_d = 1'b1;
      end else begin
         write_en_d   = 1'b0;
      end
   end

   // Scoreboard next state: the clear is applied first so a same-register set wins,
   // since the newly issued instruction now owns that register.
   always_comb begin
      busy_d = busy_q;
      if (write_en_q) begin
         busy_d[wreg_q] = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      if (bus.sb_set) begin
         busy_d[bus.sb_reg] = 1'b1;
      end else begin
         busy_d[bus.sb_reg] = busy_d[bus.sb_reg];
      end
   end

   // State registers; reset discards any in-flight write and primes requester 0 to win first.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en_q   <= 1'b0;
         wreg_q       <= {REG_AW{1'b0}};
         writedata_q  <= {DATA_W{1'b0}};
         last_grant_q <= 1'b1;
         busy_q       <= {NUM_REGS{1'b0}};
      end else begin
         write_en_q   <= write_en_d;
         wreg_q       <= wreg_d;
         writedata_q  <= writedata_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
      end
   end

   // Output drive: handshake and hazard flags are combinational, write port is registered.
   always_comb begin
      bus.req0_ready = grant0_s;
      bus.req1_ready = grant1_s;
      bus.stall      = busy_q[bus.chk_rega] | busy_q[bus.chk_regb];
      bus.busy       = busy_q;
      bus.write_en   = write_en_q;
      bus.wreg       = wreg_q;
      bus.writedata  = writedata_q;
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Table-driven bench: each record gives one cycle of inputs and the expected
// handshake; granted writes are queued and matched against the write port one
// cycle later, and a small scoreboard model predicts busy/stall.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
   typedef struct {
      logic        v0;
      logic [2:0]  r0;
      logic [15:0] d0;
      logic        v1;
      logic [2:0]  r1;
      logic [15:0] d1;
      logic        sb;
      logic [2:0]  sbr;
      logic [2:0]  ca;
      logic [2:0]  cb;
      logic        e0;
      logic        e1;
   } vec_t;

   logic clk;
   logic rst;
   regfile_wb_arbiter_if #(.DATA_W(16), .REG_AW(3)) bus ();

   regfile_wb_arbiter #(.DATA_W(16), .REG_AW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [18:0] exp_q[$];
   logic [7:0]  m_busy;
   logic        m_wen;
   logic [2:0]  m_wreg;
   logic [15:0] m_wdata;
   vec_t        tbl[20];
   vec_t        idle;

   function automatic vec_t mk(input logic v0, input logic [2:0] r0, input logic [15:0] d0,
                               input logic v1, input logic [2:0] r1, input logic [15:0] d1,
                               input logic sb, input logic [2:0] sbr,
                               input logic [2:0] ca, input logic [2:0] cb,
                               input logic e0, input logic e1);
      vec_t v;
      v.v0 = v0; v.r0 = r0; v.d0 = d0; v.v1 = v1; v.r1 = r1; v.d1 = d1;
      v.sb = sb; v.sbr = sbr; v.ca = ca; v.cb = cb; v.e0 = e0; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check handshake/stall, clock, check write port and scoreboard.
   task automatic run_cycle(input vec_t v, input logic do_rst);
      logic [18:0] ent;
      logic        pushed;
      rst            = do_rst;
      bus.req0_valid = v.v0; bus.req0_reg = v.r0; bus.req0_data = v.d0;
      bus.req1_valid = v.v1; bus.req1_reg = v.r1; bus.req1_data = v.d1;
      bus.sb_set     = v.sb; bus.sb_reg   = v.sbr;
      bus.chk_rega   = v.ca; bus.chk_regb = v.cb;
      #2;
      pushed = 1'b0;
      if (!do_rst) begin
         chk("req0_ready", {15'd0, bus.req0_ready}, {15'd0, v.e0});
         chk("req1_ready", {15'd0, bus.req1_ready}, {15'd0, v.e1});
         chk("stall", {15'd0, bus.stall}, {15'd0, m_busy[v.ca] | m_busy[v.cb]});
         if (v.e0) begin
            exp_q.push_back({v.r0, v.d0});
            pushed = 1'b1;
         end else if (v.e1) begin
            exp_q.push_back({v.r1, v.d1});
            pushed = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (do_rst) begin
         m_busy  = 8'h00;
         m_wen   = 1'b0;
         m_wreg  = 3'd0;
         m_wdata = 16'h0000;
         exp_q.delete();
      end else begin
         if (m_wen) m_busy[m_wreg] = 1'b0;
         if (v.sb) m_busy[v.sbr] = 1'b1;
         m_wen = pushed;
         if (pushed) begin
            ent     = exp_q.pop_front();
            m_wreg  = ent[18:16];
            m_wdata = ent[15:0];
         end
      end
      chk("write_en", {15'd0, bus.write_en}, {15'd0, m_wen});
      chk("wreg", {13'd0, bus.wreg}, {13'd0, m_wreg});
      chk("writedata", bus.writedata, m_wdata);
      chk("busy", {8'd0, bus.busy}, {8'd0, m_busy});
   endtask

   initial begin
      idle = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      //            v0    r0    d0         v1    r1    d1         sb    sbr   ca    cb    e0    e1
      tbl[0]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      tbl[1]  = mk(1'b1, 3'd3, 16'h00A5, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
      tbl[2]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
      tbl[3]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
      tbl[4]  = mk(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
      tbl[5]  = mk(1'b1, 3'd1, 16'h1112, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
      tbl[6]  = mk(1'b1, 3'd4, 16'h3333, 1'b1, 3'd5, 16'h4444, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
      tbl[7]  = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h4444, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
      tbl[8]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0);
      tbl[9]  = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 1'b0);
      tbl[10] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd5, 3'd0, 1'b0, 1'b1);
      tbl[11] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd1, 1'b0, 1'b0);
      tbl[12] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd5, 1'b0, 1'b0);
      tbl[13] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);
      tbl[14] = mk(1'b1, 3'd4, 16'h5555, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4, 1'b1, 1'b0);
      tbl[15] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b0);
      tbl[16] = mk(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 16'h6666, 1'b0, 3'd0, 3'd0, 3'd4, 1'b0, 1'b1);
      tbl[17] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd4, 3'd6, 1'b0, 1'b0);
      tbl[18] = mk(1'b1, 3'd0, 16'h0F0F, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd6, 1'b1, 1'b0);
      tbl[19] = mk(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd7, 1'b0, 1'b0);

      m_busy = 8'h00; m_wen = 1'b0; m_wreg = 3'd0; m_wdata = 16'h0000;
      rst = 1'b1;
      bus.req0_valid = 1'b0; bus.req0_reg = 3'd0; bus.req0_data = 16'h0000;
      bus.req1_valid = 1'b0; bus.req1_reg = 3'd0; bus.req1_data = 16'h0000;
      bus.sb_set = 1'b0; bus.sb_reg = 3'd0; bus.chk_rega = 3'd0; bus.chk_regb = 3'd0;
      @(posedge clk);
      #1;

      // Reset two cycles, then three idle cycles.
      run_cycle(idle, 1'b1);
      run_cycle(idle, 1'b1);
      for (int i = 0; i < 3; i++) run_cycle(idle, 1'b0);

      // Main vector table.
      for (int i = 0; i < 20; i++) run_cycle(tbl[i], 1'b0);
      chk("busy_after_collision_pair", {8'd0, bus.busy}, 16'h0040);

      // Reset while a write is in flight, with both requesters pending.
      run_cycle(mk(1'b1, 3'd7, 16'h7777, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0), 1'b0);
      chk("inflight_write_en", {15'd0, bus.write_en}, 16'h0001);
      run_cycle(mk(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0), 1'b1);
      chk("reset_drops_write", {15'd0, bus.write_en}, 16'h0000);

      // Contention after reset: requester 0 first, then alternation.
      run_cycle(mk(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0), 1'b0);
      run_cycle(mk(1'b1, 3'd1, 16'h1113, 1'b1, 3'd2, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1), 1'b0);
      run_cycle(mk(1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd5, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0), 1'b0);
      run_cycle(mk(1'b1, 3'd3, 16'hAAAB, 1'b1, 3'd5, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1), 1'b0);
      run_cycle(idle, 1'b0);
      run_cycle(idle, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
